// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder for the MEM stage.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then answers with
// a one-cycle ready pulse in RESP. Stores commit on the edge leaving RESP.
// Optional feature macro: DMEM_BYTE_LANE_EN (per-lane store enables).
// DEPTH_WORDS must not exceed 2**29, so that the ignored upper address bits exist.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [3:0]  byte_en,
  output logic [31:0] rd,
  output logic        ready,
  output logic        stall,
  output logic        addr_err
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [31:0]          wd_q;
  logic [3:0]           be_q;
  logic                 store_q;
  logic                 err_q;
  logic [31:0]          rd_q;
  logic                 ready_q;
  logic                 addr_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic                 req;
  logic                 in_err;
  logic [ADDR_BITS-1:0] in_idx;
  logic                 enter_resp;
  logic [ADDR_BITS-1:0] rsp_idx;
  logic                 rsp_store;
  logic                 rsp_err;
  logic [31:0]          wmask;

  assign req    = MemRead | MemWrite;
  assign in_idx = addr[ADDR_BITS+1:2];
  assign in_err = |addr[1:0];

  // Stall is combinational from the request only while idle.
  assign stall    = ((state_q == StIdle) && req) || (state_q == StWait);
  assign ready    = ready_q;
  assign addr_err = addr_err_q;
  assign rd       = rd_q;

  // Transfer details for the access about to enter RESP (live inputs when WAIT_CYCLES is 0).
  always_comb begin
    enter_resp = 1'b0;
    rsp_idx    = idx_q;
    rsp_store  = store_q;
    rsp_err    = err_q;
    if (state_q == StIdle) begin
      enter_resp = req && (WAIT_CYCLES == 0);
      rsp_idx    = in_idx;
      rsp_store  = MemWrite;
      rsp_err    = in_err;
    end else if (state_q == StWait) begin
      enter_resp = (cnt_q == 4'd1);
    end
  end

`ifdef DMEM_BYTE_LANE_EN
  // Expand lane enables into a bit mask.
  always_comb begin
    wmask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  end
  logic unused_bits;
  assign unused_bits = ^addr[31:ADDR_BITS+2];
`else
  // Lane enables are ignored; every store writes the full word.
  always_comb begin
    wmask = 32'hFFFF_FFFF;
  end
  logic unused_bits;
  assign unused_bits = ^{addr[31:ADDR_BITS+2], be_q};
`endif

  // Control FSM with registered response outputs; load data sampled on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wd_q       <= 32'd0;
      be_q       <= 4'd0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 32'd0;
      ready_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            idx_q   <= in_idx;
            wd_q    <= wd;
            be_q    <= byte_en;
            store_q <= MemWrite;
            err_q   <= in_err;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      ready_q    <= enter_resp;
      addr_err_q <= enter_resp && rsp_err;
      if (enter_resp && !rsp_store) rd_q <= rsp_err ? 32'd0 : mem[rsp_idx];
    end
  end

  // Array write on the edge leaving RESP; not reset, and a reset edge drops the store.
  always_ff @(posedge clk) begin
    if (rst && (state_q == StResp) && store_q && !err_q) begin
      mem[idx_q] <= (mem[idx_q] & ~wmask) | (wd_q & wmask);
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core. It is the memory-side end of the MEM-stage load/store interface and replaces the zero-latency data memory with a handshaked responder. A request is serviced after a fixed, parameterised number of wait states. A `stall` output holds the pipeline until `ready` completes the transfer.

## Interface
Parameters:
- `DEPTH_WORDS`, 256, number of 32-bit words; power of two, at least 2; `ADDR_BITS` = log2(`DEPTH_WORDS`).
- `WAIT_CYCLES`, 2, wait states between acceptance and response; 0 to 15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `MemRead`  in  1  load request.
- `MemWrite`  in  1  store request.
- `addr`  in  32  byte address; word index is `addr[ADDR_BITS+1:2]`.
- `wd`  in  32  store data.
- `byte_en`  in  4  store lane enables; bit i covers `wd[8i+7:8i]`.
- `rd`  out  32  load data.
- `ready`  out  1  one-cycle response strobe.
- `stall`  out  1  pipeline hold request.
- `addr_err`  out  1  misaligned-access flag; qualified by `ready`.

## Operation
- A request is present when `MemRead | MemWrite` is high.
- If `MemRead` and `MemWrite` are both high, the request is treated as a store.
- FSM states:
  - IDLE: a request present in this state is accepted at the clock edge. `addr`, `wd`, `byte_en`, the request type and the misalignment result are latched. The wait counter is loaded with `WAIT_CYCLES`. Next state is WAIT, or RESP directly if `WAIT_CYCLES` = 0.
  - WAIT: the counter decrements each cycle. When it would reach 0, the next state is RESP.
  - RESP: `ready` = 1. Next state is always IDLE.
- Store commit: the write happens at the edge leaving RESP. Load data is read from the array at the edge entering RESP, using the latched index, and registered into `rd`.
- Misalignment: if `addr[1:0]` ≠ 0, `addr_err` = 1 during RESP. A store is suppressed and a load returns `rd` = 0. The full wait-state timing still applies.
- Out-of-range addresses: upper address bits above `ADDR_BITS+1` are ignored, so the index wraps modulo `DEPTH_WORDS`.
- Request stability: the requester holds the request and its fields stable from acceptance through RESP; inputs are not sampled after acceptance. A request seen in the IDLE cycle after RESP is a new request.
- `stall` = (IDLE and a request present) or WAIT. `stall` is 0 in RESP, so the pipeline advances at the RESP edge.
- `rd` changes only on a load response and holds otherwise. A store response leaves `rd` unchanged.
- Read-after-write: a load returns data that includes all previously committed stores, including a store that committed at the immediately preceding RESP.
- Reset (`rst` = 0 at an edge), including mid-transaction:
  - state goes to IDLE; `ready` = 0, `stall` = 0, `addr_err` = 0, `rd` = 0, counter = 0;
  - a pending store is discarded;
  - array contents are retained and are not cleared by reset.

## Timing
- Request accepted at the end of cycle N.
- WAIT occupies cycles N+1 to N+`WAIT_CYCLES`.
- RESP occurs in cycle N+`WAIT_CYCLES`+1:
  - `ready`, `rd` and `addr_err` are valid in that cycle;
  - a store is visible from cycle N+`WAIT_CYCLES`+2.
- `stall` is high in cycles N to N+`WAIT_CYCLES`. `stall` is combinational from the request inputs in IDLE only.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle N+`WAIT_CYCLES`+2, giving a throughput of one access per `WAIT_CYCLES`+2 cycles.
- `ready`, `rd` and `addr_err` are decoded from registered state and data, with no combinational path from the inputs.

## Configuration
- Macro: `DMEM_BYTE_LANE_EN`.
- Defined: a store writes only the lanes whose `byte_en` bit is 1. `byte_en` = 4'b0000 makes the store a no-op that still produces a response.
- Undefined: `byte_en` is ignored and every store writes all four lanes. The port remains present.

## Test plan
All scenarios use `WAIT_CYCLES` = 2 and `DEPTH_WORDS` = 256.
- Store then load: store 32'hDEADBEEF to address 32'h40, then load 32'h40. Each `ready` pulses exactly 3 cycles after acceptance, `stall` is high for 3 cycles per access, and the load returns `rd` = 32'hDEADBEEF with `addr_err` = 0.
- Misaligned access: store 32'h12345678 to 32'h41. `addr_err` = 1 at `ready`, and a later load from 32'h40 still returns 32'hDEADBEEF. A load from 32'h43 returns `rd` = 0 with `addr_err` = 1.
- Address wrap: store 32'hA5A5A5A5 to 32'h400, then load 32'h0, which returns 32'hA5A5A5A5.
- Byte lanes: with 32'h11223344 stored at 32'h8, store 32'hFFFFFFFF with `byte_en` = 4'b0101. With the macro defined, a load returns 32'h11FF33FF; without it, the load returns 32'hFFFFFFFF.
- Reset mid-operation: accept a store of 32'hCAFEF00D to 32'h10, then drive `rst` = 0 in the WAIT cycle. All outputs are 0 and the state is IDLE on the next cycle, and a later load from 32'h10 returns the old contents, not 32'hCAFEF00D.
- Simultaneous and back-to-back requests: drive `MemRead` = `MemWrite` = 1 with `wd` = 32'h55 to 32'h20; the access is performed as a store. A load request presented in the cycle after RESP is accepted immediately and returns 32'h55.
